// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared constants for the digital-clock timekeeping core: time field widths,
// field limits, the alarm ring state encoding and range-check helpers used
// when validating load strobes.
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int HH_W   = 5;
    localparam int MS_W   = 6;
    localparam int HH_MAX = 23;
    localparam int MS_MAX = 59;

    // Ring state machine encoding
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RING = 1'b1;

    function automatic logic hh_in_range(input logic [HH_W-1:0] v);
        return v <= HH_W'(HH_MAX);
    endfunction

    function automatic logic ms_in_range(input logic [MS_W-1:0] v);
        return v <= MS_W'(MS_MAX);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-N up counter with synchronous load, used for the ss, mm and hh
// fields of the clock.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset (count returns to 0)
//   i_en        in   advance by one this cycle
//   i_load      in   load i_load_val this cycle (overrides i_en)
//   i_load_val  in   value to load
//   o_count     out  current count
//   o_next      out  value the count takes at this edge when not loading
//   o_carry     out  i_en while at MODULUS-1 (wrap to 0 this edge)
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_next,
    output logic             o_carry
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == WIDTH'(MODULUS - 1));
    assign o_carry  = i_en & w_at_max;
    assign o_next   = !i_en    ? r_count :
                      w_at_max ? '0      : r_count + 1'b1;
    assign o_count  = r_count;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values and the ss->mm->hh carry chain settles in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else begin
            r_count <= o_next;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
// 24-hour HH:MM:SS timekeeper with alarm. Each rising edge of the divider's
// slow square wave advances the time by one second. A loadable alarm (HH:MM)
// rings when a tick lands on HH:MM:00 and stops on dismiss, disarm, a valid
// alarm reload, or after RING_SECS ticks.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   tick_in               divider level output; rising edge = one second
//   set_time, set_hh/mm/ss    one-cycle time load strobe and fields
//   set_alarm, al_hh/al_mm    one-cycle alarm load strobe and fields
//   alarm_en              alarm armed while high
//   dismiss               one-cycle strobe, stops ringing
//   hh, mm, ss            current time
//   sec_pulse             one cycle when the time advanced by a tick
//   set_err               one cycle when a load strobe carried a bad field
//   alarm_ring            high while ringing
// -----------------------------------------------------------------------------
module time_keeper
    import clock_pkg::*;
#(
    parameter int RING_SECS = 60
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick_in,
    input  logic            set_time,
    input  logic [HH_W-1:0] set_hh,
    input  logic [MS_W-1:0] set_mm,
    input  logic [MS_W-1:0] set_ss,
    input  logic            set_alarm,
    input  logic [HH_W-1:0] al_hh,
    input  logic [MS_W-1:0] al_mm,
    input  logic            alarm_en,
    input  logic            dismiss,
    output logic [HH_W-1:0] hh,
    output logic [MS_W-1:0] mm,
    output logic [MS_W-1:0] ss,
    output logic            sec_pulse,
    output logic            set_err,
    output logic            alarm_ring
);

    localparam int CNT_W = $clog2(RING_SECS) + 1;

    logic            r_tick_d;
    logic            r_sec_pulse;
    logic            r_set_err;
    logic [HH_W-1:0] r_al_hh;
    logic [MS_W-1:0] r_al_mm;
    logic            r_state;
    logic [CNT_W-1:0] r_ring_cnt;

    logic            w_rise;
    logic            w_time_ok;
    logic            w_alarm_ok;
    logic            w_load_time;
    logic            w_load_alarm;
    logic            w_advance;
    logic            w_ss_carry;
    logic            w_mm_carry;
    logic [MS_W-1:0] w_ss_next;
    logic [MS_W-1:0] w_mm_next;
    logic [HH_W-1:0] w_hh_next;
    logic            w_match;
    logic            w_last_sec;
    logic            w_ring_exit;

    assign w_rise       = tick_in & ~r_tick_d;
    assign w_time_ok    = hh_in_range(set_hh) & ms_in_range(set_mm) & ms_in_range(set_ss);
    assign w_alarm_ok   = hh_in_range(al_hh) & ms_in_range(al_mm);
    assign w_load_time  = set_time & w_time_ok;
    assign w_load_alarm = set_alarm & w_alarm_ok;
    // A valid time load wins over a tick arriving in the same cycle; that
    // tick is dropped rather than applied on top of the loaded value.
    assign w_advance    = w_rise & ~w_load_time;

    mod_counter #(.MODULUS(MS_MAX + 1), .WIDTH(MS_W)) u_ss (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_advance),
        .i_load     (w_load_time),
        .i_load_val (set_ss),
        .o_count    (ss),
        .o_next     (w_ss_next),
        .o_carry    (w_ss_carry)
    );

    mod_counter #(.MODULUS(MS_MAX + 1), .WIDTH(MS_W)) u_mm (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_ss_carry),
        .i_load     (w_load_time),
        .i_load_val (set_mm),
        .o_count    (mm),
        .o_next     (w_mm_next),
        .o_carry    (w_mm_carry)
    );

    // Midnight rollover has no consumer, so the hour carry is left open.
    mod_counter #(.MODULUS(HH_MAX + 1), .WIDTH(HH_W)) u_hh (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_mm_carry),
        .i_load     (w_load_time),
        .i_load_val (set_hh),
        .o_count    (hh),
        .o_next     (w_hh_next),
        .o_carry    ()
    );

    // Match is evaluated on the post-tick time so the ring starts on the
    // same edge as the matching sec_pulse; loads never reach this term.
    assign w_match     = w_advance & alarm_en & (w_ss_next == '0) &
                         (w_mm_next == r_al_mm) & (w_hh_next == r_al_hh);
    assign w_last_sec  = (r_ring_cnt == CNT_W'(RING_SECS - 1));
    assign w_ring_exit = dismiss | ~alarm_en | w_load_alarm | (w_rise & w_last_sec);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_d    <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_set_err   <= 1'b0;
            r_al_hh     <= '0;
            r_al_mm     <= '0;
        end else begin
            r_tick_d    <= tick_in;
            r_sec_pulse <= w_advance;
            r_set_err   <= (set_time & ~w_time_ok) | (set_alarm & ~w_alarm_ok);
            if (w_load_alarm) begin
                r_al_hh <= al_hh;
                r_al_mm <= al_mm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ring_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_match) begin
                r_state    <= ST_RING;
                r_ring_cnt <= '0;
            end
        end else begin
            if (w_ring_exit) begin
                r_state <= ST_IDLE;
            end else if (w_rise) begin
                r_ring_cnt <= r_ring_cnt + 1'b1;
            end
        end
    end

    assign sec_pulse  = r_sec_pulse;
    assign set_err    = r_set_err;
    assign alarm_ring = (r_state == ST_RING);

endmodule

// File: tb/tb_time_keeper.sv
// -----------------------------------------------------------------------------
// tb_time_keeper
// Scoreboarded bench for time_keeper. Stimulus drives inputs on the falling
// edge and pushes the reference model's expected post-edge outputs into a
// queue; a monitor pops one entry after each rising edge and compares.
// The model keeps time as seconds-of-day and the alarm as minute-of-day.
// -----------------------------------------------------------------------------
module tb_time_keeper;

    localparam int RING_SECS = 3;
    localparam int DAY_SECS  = 86400;

    typedef struct packed {
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic       sp;
        logic       err;
        logic       ring;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_in;
    logic       set_time;
    logic [4:0] set_hh;
    logic [5:0] set_mm;
    logic [5:0] set_ss;
    logic       set_alarm;
    logic [4:0] al_hh;
    logic [5:0] al_mm;
    logic       alarm_en;
    logic       dismiss;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       sec_pulse;
    logic       set_err;
    logic       alarm_ring;

    time_keeper #(.RING_SECS(RING_SECS)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .set_time   (set_time),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_ss     (set_ss),
        .set_alarm  (set_alarm),
        .al_hh      (al_hh),
        .al_mm      (al_mm),
        .alarm_en   (alarm_en),
        .dismiss    (dismiss),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .sec_pulse  (sec_pulse),
        .set_err    (set_err),
        .alarm_ring (alarm_ring)
    );

    always #5 clk = ~clk;

    obs_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int m_t    = 0;    // seconds since midnight
    int m_al   = 0;    // alarm minute of day
    int m_cnt  = 0;    // ticks seen while ringing
    bit m_prev = 0;    // previous tick_in level
    bit m_ring = 0;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d:%0d:%0d sp=%b err=%b ring=%b, expected %0d:%0d:%0d sp=%b err=%b ring=%b",
                     name, act.hh, act.mm, act.ss, act.sp, act.err, act.ring,
                     exp.hh, exp.mm, exp.ss, exp.sp, exp.err, exp.ring);
        end
    endtask

    // Apply current inputs to the model, queue the expected result, wait a cycle.
    task automatic step();
        obs_t e;
        bit rise, t_ok, a_ok, load_t, adv, match, leave;
        e = '0;
        if (reset) begin
            m_t = 0; m_al = 0; m_cnt = 0; m_prev = 0; m_ring = 0;
        end else begin
            rise   = tick_in && !m_prev;
            m_prev = tick_in;
            t_ok   = (set_hh < 24) && (set_mm < 60) && (set_ss < 60);
            a_ok   = (al_hh < 24) && (al_mm < 60);
            load_t = set_time && t_ok;
            adv    = rise && !load_t;
            e.err  = (set_time && !t_ok) || (set_alarm && !a_ok);
            if (load_t) m_t = set_hh * 3600 + set_mm * 60 + set_ss;
            else if (adv) m_t = (m_t + 1) % DAY_SECS;
            match = adv && alarm_en && (m_t % 60 == 0) && (m_t / 60 == m_al);
            if (m_ring) begin
                leave = dismiss || !alarm_en || (set_alarm && a_ok) ||
                        (rise && m_cnt == RING_SECS - 1);
                if (leave) m_ring = 0;
                else if (rise) m_cnt++;
            end else if (match) begin
                m_ring = 1;
                m_cnt  = 0;
            end
            if (set_alarm && a_ok) m_al = al_hh * 60 + al_mm;
            e.sp = adv;
        end
        e.hh   = 5'(m_t / 3600);
        e.mm   = 6'((m_t / 60) % 60);
        e.ss   = 6'(m_t % 60);
        e.ring = m_ring;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic clear_strobes();
        set_time = 0; set_alarm = 0; dismiss = 0; reset = 0;
    endtask

    task automatic idle(input int n);
        clear_strobes();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tick();
        clear_strobes();
        tick_in = 1; step(); step();
        tick_in = 0; step(); step();
    endtask

    task automatic load_time(input int h, input int m, input int s);
        clear_strobes();
        set_time = 1; set_hh = 5'(h); set_mm = 6'(m); set_ss = 6'(s);
        step();
        set_time = 0;
    endtask

    task automatic load_alarm(input int h, input int m);
        clear_strobes();
        set_alarm = 1; al_hh = 5'(h); al_mm = 6'(m);
        step();
        set_alarm = 0;
    endtask

    task automatic pulse_dismiss();
        clear_strobes();
        dismiss = 1; step();
        dismiss = 0;
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        obs_t a, e;
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{hh: hh, mm: mm, ss: ss, sp: sec_pulse, err: set_err, ring: alarm_ring};
                check($sformatf("cycle%0d", cyc), a, e);
            end
            cyc++;
        end
    end

    initial begin
        int half;
        int tgt;
        reset = 1; tick_in = 0; set_time = 0; set_alarm = 0; dismiss = 0;
        set_hh = 0; set_mm = 0; set_ss = 0; al_hh = 0; al_mm = 0; alarm_en = 0;
        step(); step();
        idle(2);

        // Three ticks from reset
        repeat (3) tick();

        // Midnight rollover
        load_time(23, 59, 59);
        idle(1);
        tick();

        // Out-of-range loads
        load_time(24, 0, 0);
        idle(1);
        load_alarm(7, 60);
        idle(1);

        // Alarm match then dismiss
        alarm_en = 1;
        load_alarm(7, 30);
        load_time(7, 29, 59);
        tick();
        idle(2);
        pulse_dismiss();
        idle(2);

        // Timeout after RING_SECS ticks
        load_time(7, 29, 59);
        tick();
        repeat (RING_SECS + 1) tick();

        // Disarm mid-ring
        load_time(7, 29, 59);
        tick();
        tick();
        alarm_en = 0; idle(2);
        alarm_en = 1; idle(1);

        // Load landing exactly on the match does not ring
        load_time(7, 30, 0);
        idle(2);

        // Load coincident with a rising tick
        clear_strobes();
        tick_in = 1; set_time = 1; set_hh = 12; set_mm = 34; set_ss = 56;
        step();
        set_time = 0; step();
        tick_in = 0; step(); step();

        // Both strobes together, one bad
        clear_strobes();
        set_time = 1; set_hh = 1; set_mm = 2; set_ss = 3;
        set_alarm = 1; al_hh = 25; al_mm = 0;
        step();
        idle(1);

        // Reset while ringing
        load_alarm(7, 30);
        load_time(7, 29, 59);
        tick();
        clear_strobes(); reset = 1; step();
        idle(2);

        // Randomized traffic
        half = 2;
        for (int i = 0; i < 4000; i++) begin
            clear_strobes();
            if (--half <= 0) begin
                tick_in = ~tick_in;
                half = $urandom_range(1, 4);
            end
            set_hh = 5'($urandom); set_mm = 6'($urandom); set_ss = 6'($urandom);
            al_hh  = 5'($urandom); al_mm  = 6'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                set_time = 1;
                case ($urandom_range(0, 3))
                    0: begin
                        set_hh = 5'($urandom_range(24, 31));
                    end
                    1: begin
                        tgt = (m_al * 60 + DAY_SECS - $urandom_range(1, 3)) % DAY_SECS;
                        set_hh = 5'(tgt / 3600); set_mm = 6'((tgt / 60) % 60); set_ss = 6'(tgt % 60);
                    end
                    default: begin
                        set_hh = 5'($urandom_range(0, 23));
                        set_mm = 6'($urandom_range(0, 59));
                        set_ss = 6'($urandom_range(0, 63));
                    end
                endcase
            end
            if ($urandom_range(0, 59) == 0) begin
                set_alarm = 1;
                if ($urandom_range(0, 3) != 0) begin
                    tgt = (m_t / 60 + 1) % 1440;
                    al_hh = 5'(tgt / 60); al_mm = 6'(tgt % 60);
                end
            end
            dismiss  = ($urandom_range(0, 49) == 0);
            alarm_en = ($urandom_range(0, 29) != 0);
            reset    = ($urandom_range(0, 499) == 0);
            if (reset) tick_in = 0;
            step();
        end

        idle(4);
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
